// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the miniRISC fetch stage: holds the PC, offers PC+STEP,
// applies branch redirects with a one-cycle flush bubble, honours stall and halt, counts fetches.
module pc_sequencer #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              STEP      = 4,
    parameter int              CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 STALL,
    input  logic                 BR_TAKEN,
    input  logic [WIDTH-1:0]     BR_TARGET,
    input  logic                 HALT,
    output logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     NPC,
    output logic                 FETCH_VALID,
    output logic                 HALTED,
    output logic [CNT_WIDTH-1:0] FETCH_CNT
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t state;

    assign NPC = PC + WIDTH'(STEP);

    // FETCH_VALID and HALTED are registered alongside the state so they always decode it exactly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_BOOT;
            PC          <= RESET_PC;
            FETCH_VALID <= 1'b0;
            HALTED      <= 1'b0;
            FETCH_CNT   <= '0;
        end else begin
            case (state)
                S_BOOT, S_FLUSH: begin
                    if (HALT) begin
                        state       <= S_HALTED;
                        FETCH_VALID <= 1'b0;
                        HALTED      <= 1'b1;
                    end else begin
                        state       <= S_RUN;
                        FETCH_VALID <= 1'b1;
                        HALTED      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (HALT) begin
                        state       <= S_HALTED;
                        FETCH_VALID <= 1'b0;
                        HALTED      <= 1'b1;
                    end else if (BR_TAKEN) begin
                        // The branch itself was a real fetch, so it is counted even under stall.
                        state       <= S_FLUSH;
                        PC          <= BR_TARGET;
                        FETCH_CNT   <= FETCH_CNT + CNT_WIDTH'(1);
                        FETCH_VALID <= 1'b0;
                    end else if (!STALL) begin
                        PC          <= NPC;
                        FETCH_CNT   <= FETCH_CNT + CNT_WIDTH'(1);
                    end
                end
                S_HALTED: begin
                    state       <= S_HALTED;
                    FETCH_VALID <= 1'b0;
                    HALTED      <= 1'b1;
                end
                default: begin
                    state       <= S_BOOT;
                    FETCH_VALID <= 1'b0;
                    HALTED      <= 1'b0;
                end
            endcase
        end
    end

endmodule
